mem_ctrl: RTL

Memory controller that shares the single byte-wide RAM port between the instruction-fetch (IF) stage and the MEM stage of the pipeline. It serialises each 1-, 2- or 4-byte access into consecutive byte cycles, assembles read words little-endian, and signals completion with a one-cycle done pulse per requester. MEM has fixed priority over IF. An in-flight IF read can be aborted on a branch redirect.

---
 rtl/mem_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Purpose  : Shares one byte-wide RAM port between IF and MEM; serialises
//            1/2/4-byte accesses, assembles little-endian read words.
// Revision : 1.0
// ============================================================================
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_abort,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        mem_req,
  input  logic        mem_wr_en,
  input  logic [31:0] mem_addr_in,
  input  logic [1:0]  mem_len,
  input  logic [31:0] mem_wdata,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  input  logic [7:0]  ram_din,
  output logic [7:0]  ram_dout,
  output logic [31:0] ram_a,
  output logic        ram_wr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state,   w_state;
  logic        r_own_mem, w_own_mem;
  logic [31:0] r_base,    w_base;
  logic [2:0]  r_n,       w_n;
  logic        r_wr,      w_wr;
  logic [31:0] r_wdata,   w_wdata;
  logic [2:0]  r_cnt,     w_cnt;
  logic [31:0] r_asm,     w_asm;

  logic [31:0] w_ram_a;
  logic [7:0]  w_ram_dout;
  logic        w_ram_wr;
  logic        w_if_done;
  logic        w_mem_done;
  logic [31:0] w_if_data;
  logic [31:0] w_mem_rdata;

  logic [2:0]  w_cnt_inc;
  logic [1:0]  w_lane;
  logic [31:0] w_asm_cap;
  logic [2:0]  w_len_n;

  assign w_cnt_inc = r_cnt + 3'd1;
  // ram_din in the cycle with counter value c belongs to byte c-1
  assign w_lane    = r_cnt[1:0] - 2'd1;

  always_comb begin
    w_asm_cap = r_asm;
    w_asm_cap[{w_lane, 3'b000} +: 8] = ram_din;
  end

  always_comb begin
    case (mem_len)
      2'b00:   w_len_n = 3'd1;
      2'b01:   w_len_n = 3'd2;
      default: w_len_n = 3'd4;
    endcase
  end

  always_comb begin
    w_state     = r_state;
    w_own_mem   = r_own_mem;
    w_base      = r_base;
    w_n         = r_n;
    w_wr        = r_wr;
    w_wdata     = r_wdata;
    w_cnt       = r_cnt;
    w_asm       = r_asm;
    w_ram_a     = ram_a;
    w_ram_dout  = ram_dout;
    w_ram_wr    = 1'b0;
    w_if_done   = 1'b0;
    w_mem_done  = 1'b0;
    w_if_data   = if_data;
    w_mem_rdata = mem_rdata;

    case (r_state)
      S_IDLE: begin
        if (mem_req) begin
          w_state    = S_BUSY;
          w_own_mem  = 1'b1;
          w_base     = mem_addr_in;
          w_n        = w_len_n;
          w_wr       = mem_wr_en;
          w_wdata    = mem_wdata;
          w_cnt      = 3'd0;
          w_asm      = 32'd0;
          w_ram_a    = mem_addr_in;
          w_ram_wr   = mem_wr_en;
          if (mem_wr_en) w_ram_dout = mem_wdata[7:0];
        end else if (if_req && !if_abort) begin
          w_state    = S_BUSY;
          w_own_mem  = 1'b0;
          w_base     = if_addr;
          w_n        = 3'd4;
          w_wr       = 1'b0;
          w_cnt      = 3'd0;
          w_asm      = 32'd0;
          w_ram_a    = if_addr;
        end
      end

      S_BUSY: begin
        if (!r_own_mem && if_abort) begin
          w_state = S_IDLE;
        end else if (r_wr) begin
          if (r_cnt == r_n - 3'd1) begin
            w_state    = S_DONE;
            w_mem_done = 1'b1;
          end else begin
            w_cnt      = w_cnt_inc;
            w_ram_wr   = 1'b1;
            w_ram_a    = r_base + {29'd0, w_cnt_inc};
            w_ram_dout = r_wdata[{w_cnt_inc[1:0], 3'b000} +: 8];
          end
        end else begin
          if (r_cnt != 3'd0) w_asm = w_asm_cap;
          if (r_cnt == r_n) begin
            w_state = S_DONE;
            if (r_own_mem) begin
              w_mem_done  = 1'b1;
              w_mem_rdata = w_asm_cap;
            end else begin
              w_if_done = 1'b1;
              w_if_data = w_asm_cap;
            end
          end else begin
            w_cnt = w_cnt_inc;
            if (w_cnt_inc < r_n) w_ram_a = r_base + {29'd0, w_cnt_inc};
          end
        end
      end

      S_DONE: w_state = S_IDLE;

      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_own_mem <= 1'b0;
      r_base    <= 32'd0;
      r_n       <= 3'd0;
      r_wr      <= 1'b0;
      r_wdata   <= 32'd0;
      r_cnt     <= 3'd0;
      r_asm     <= 32'd0;
      ram_a     <= 32'd0;
      ram_dout  <= 8'd0;
      ram_wr    <= 1'b0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
      if_data   <= 32'd0;
      mem_rdata <= 32'd0;
    end else if (rdy) begin
      r_state   <= w_state;
      r_own_mem <= w_own_mem;
      r_base    <= w_base;
      r_n       <= w_n;
      r_wr      <= w_wr;
      r_wdata   <= w_wdata;
      r_cnt     <= w_cnt;
      r_asm     <= w_asm;
      ram_a     <= w_ram_a;
      ram_dout  <= w_ram_dout;
      ram_wr    <= w_ram_wr;
      if_done   <= w_if_done;
      mem_done  <= w_mem_done;
      if_data   <= w_if_data;
      mem_rdata <= w_mem_rdata;
    end
  end

endmodule
`default_nettype wire
